gpio_config_shift: RTL

//  Per-pad configuration stage downstream of the per-pad tie-cell defaults block.
//  - Resets the pad configuration to the 10-bit gpio_defaults word.
//  - Accepts reconfiguration over the daisy-chained serial loader and commits it on a load pulse.
//  - Muxes management vs user pad signals from the committed config.

---
 rtl/gpio_config_pkg.sv | 23 ++
 rtl/gpio_pad_mux.sv | 17 +
 rtl/gpio_config_shift.sv | 126 ++++++++++++
 3 files changed

// File: rtl/gpio_config_pkg.sv
// Shared constants for the per-pad GPIO configuration stage: word width,
// named bit positions of the configuration word and the loader FSM states.
package gpio_config_pkg;

    localparam int GPIO_CFG_WIDTH = 10;

    localparam int MGMT_ENA = 0;
    localparam int OUTENB   = 1;
    localparam int HOLDOVER = 2;
    localparam int INENB    = 3;
    localparam int PD_SEL   = 4;
    localparam int PU_SEL   = 5;
    localparam int SCHMITT  = 6;
    localparam int SLEW     = 7;
    localparam int DRV0     = 8;
    localparam int DRV1     = 9;

    typedef enum logic {
        IDLE     = 1'b0,
        SHIFTING = 1'b1
    } cfg_state_e;

endpackage

// File: rtl/gpio_pad_mux.sv
// Combinational pad select: management or user drive, with the config
// output-disable bit forcing the (active-low) enable off.
module gpio_pad_mux (
    input  logic mgmt_ena,
    input  logic outenb,
    input  logic mgmt_gpio_out,
    input  logic mgmt_gpio_oeb,
    input  logic user_gpio_out,
    input  logic user_gpio_oeb,
    output logic pad_out,
    output logic pad_oeb
);

    assign pad_out = mgmt_ena ? mgmt_gpio_out : user_gpio_out;
    assign pad_oeb = outenb | (mgmt_ena ? mgmt_gpio_oeb : user_gpio_oeb);

endmodule

// File: rtl/gpio_config_shift.sv
// Per-pad configuration register with a daisy-chained serial loader and a
// pad output mux driven from the committed configuration.
module gpio_config_shift
    import gpio_config_pkg::*;
#(
    parameter int WIDTH = GPIO_CFG_WIDTH,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] gpio_defaults,
    input  logic             reload_defaults,
    input  logic             serial_shift,
    input  logic             serial_data_in,
    input  logic             serial_load,
    output logic             serial_data_out,
    output logic [WIDTH-1:0] pad_config,
    output logic             load_error,
    input  logic             mgmt_gpio_out,
    input  logic             mgmt_gpio_oeb,
    input  logic             user_gpio_out,
    input  logic             user_gpio_oeb,
    output logic             pad_out,
    output logic             pad_oeb
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] cfg_q,   cfg_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q,   err_d;
    cfg_state_e       state_q, state_d;

    // Next-state for loader datapath and FSM; a load is judged on pre-edge state.
    always_comb begin
        shift_d = shift_q;
        cfg_d   = cfg_q;
        count_d = count_q;
        err_d   = err_q;
        state_d = state_q;
        if (reload_defaults) begin
            shift_d = gpio_defaults;
            cfg_d   = gpio_defaults;
            count_d = CNT_ZERO;
            state_d = IDLE;
        end else begin
            if (serial_load) begin
                if (count_q == CNT_FULL) begin
                    cfg_d = shift_q;
                    err_d = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
                count_d = CNT_ZERO;
            end else begin
                count_d = count_q;
            end
            // Long chains over-shift legally, so the counter saturates.
            if (serial_shift) begin
                shift_d = {shift_q[WIDTH-2:0], serial_data_in};
                if (serial_load) begin
                    count_d = CNT_ONE;
                end else if (count_q == CNT_FULL) begin
                    count_d = CNT_FULL;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end else begin
                shift_d = shift_q;
            end
            case (state_q)
                IDLE: begin
                    if (serial_shift) begin
                        state_d = SHIFTING;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SHIFTING: begin
                    if (serial_load) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SHIFTING;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with synchronous reset to the tie-cell defaults.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= gpio_defaults;
            cfg_q   <= gpio_defaults;
            count_q <= CNT_ZERO;
            err_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            shift_q <= shift_d;
            cfg_q   <= cfg_d;
            count_q <= count_d;
            err_q   <= err_d;
            state_q <= state_d;
        end
    end

    assign serial_data_out = shift_q[WIDTH-1];
    assign pad_config      = cfg_q;
    assign load_error      = err_q;

    gpio_pad_mux u_pad_mux (
        .mgmt_ena      (cfg_q[MGMT_ENA]),
        .outenb        (cfg_q[OUTENB]),
        .mgmt_gpio_out (mgmt_gpio_out),
        .mgmt_gpio_oeb (mgmt_gpio_oeb),
        .user_gpio_out (user_gpio_out),
        .user_gpio_oeb (user_gpio_oeb),
        .pad_out       (pad_out),
        .pad_oeb       (pad_oeb)
    );

endmodule
